// File: rtl/type_buffer_pkg.sv
// Shared constants for the TypeRacer text path: key codes, FSM encoding and
// the default packing (LEN slots of CW bits) used by type_buffer and the VGA side.
package type_buffer_pkg;

  localparam int LEN_DEF  = 25;
  localparam int CW_DEF   = 5;
  localparam int CNTW_DEF = 16;

  localparam logic [4:0] KEY_NONE  = 5'd0;
  localparam logic [4:0] KEY_A     = 5'd1;
  localparam logic [4:0] KEY_SPACE = 5'd27;
  localparam logic [4:0] KEY_BS    = 5'd31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TYPING = 2'd1,
    DONE   = 2'd2
  } state_t;

  // A zero or oversized target length means "use the whole buffer".
  function automatic logic [4:0] norm_len(input logic [4:0] raw, input logic [4:0] max_len);
    return ((raw == 5'd0) || (raw > max_len)) ? max_len : raw;
  endfunction

endpackage

// File: rtl/type_buffer_if.sv
// Keyboard-event inputs and typed-text/statistics outputs of type_buffer.
// master = the side driving keys and target, slave = type_buffer itself.
interface type_buffer_if
  import type_buffer_pkg::*;
#(
  parameter int LEN  = LEN_DEF,
  parameter int CW   = CW_DEF,
  parameter int CNTW = CNTW_DEF
);

  logic              start;
  logic              key_valid;
  logic [CW-1:0]     key_code;
  logic [LEN*CW-1:0] target;
  logic [4:0]        target_len;

  logic [LEN*CW-1:0] type_text;
  logic [LEN-1:0]    correct;
  logic [4:0]        cursor;
  logic [CNTW-1:0]   keystrokes;
  logic [CNTW-1:0]   errors;
  logic              busy;
  logic              done;

  modport master (
    output start, key_valid, key_code, target, target_len,
    input  type_text, correct, cursor, keystrokes, errors, busy, done
  );

  modport slave (
    input  start, key_valid, key_code, target, target_len,
    output type_text, correct, cursor, keystrokes, errors, busy, done
  );

endinterface

// File: rtl/type_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [CNTW-1:0] count
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc)
      count <= sat_inc(count);
  end

endmodule

// File: rtl/type_buffer.sv
// Typed-text buffer for one race: stores keys into slots, marks them against the
// target text, counts keystrokes/errors and frames the race as IDLE/TYPING/DONE.
module type_buffer
  import type_buffer_pkg::*;
#(
  parameter int LEN  = LEN_DEF,
  parameter int CW   = CW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic clk,
  input  logic rst,
  type_buffer_if.slave bus
);

  localparam logic [4:0] LEN5 = 5'(LEN);

  state_t            state_p1;
  logic [LEN*CW-1:0] type_p1;
  logic [LEN-1:0]    correct_p1;
  logic [4:0]        cursor_p1;
  logic [4:0]        len_p1;
  logic              busy_p1;
  logic              done_p1;

  logic              is_char;
  logic              is_bs;
  logic              acc_char;
  logic              acc_bs;
  logic              mismatch;
  logic              err_inc;
  logic [4:0]        cur_inc;
  logic [4:0]        cur_dec;
  logic [CW-1:0]     tgt_char;
  int                wr_idx;
  int                bs_idx;
  logic [CNTW-1:0]   keys_cnt;
  logic [CNTW-1:0]   errs_cnt;

  // Stage p0: decode the key event against the current slot
  always_comb begin
    is_char  = bus.key_valid && (bus.key_code >= CW'(KEY_A)) && (bus.key_code <= CW'(KEY_SPACE));
    is_bs    = bus.key_valid && (bus.key_code == CW'(KEY_BS));
    // start always pre-empts a key arriving on the same edge
    acc_char = !bus.start && (state_p1 == TYPING) && is_char;
    acc_bs   = !bus.start && (state_p1 == TYPING) && is_bs && (cursor_p1 != 5'd0);
    cur_inc  = cursor_p1 + 5'd1;
    cur_dec  = cursor_p1 - 5'd1;
    wr_idx   = (cursor_p1 < LEN5) ? int'(cursor_p1) : 0;
    bs_idx   = (cursor_p1 != 5'd0) ? int'(cur_dec) : 0;
    tgt_char = bus.target[wr_idx*CW +: CW];
    mismatch = (bus.key_code != tgt_char);
    err_inc  = acc_char && mismatch;
  end

  // Stage p1: slot, cursor and state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1   <= IDLE;
      type_p1    <= '0;
      correct_p1 <= '0;
      cursor_p1  <= 5'd0;
      len_p1     <= LEN5;
      busy_p1    <= 1'b0;
      done_p1    <= 1'b0;
    end else if (bus.start) begin
      state_p1   <= TYPING;
      type_p1    <= '0;
      correct_p1 <= '0;
      cursor_p1  <= 5'd0;
      len_p1     <= norm_len(bus.target_len, LEN5);
      busy_p1    <= 1'b1;
      done_p1    <= 1'b0;
    end else if (acc_char) begin
      type_p1[wr_idx*CW +: CW] <= bus.key_code;
      correct_p1[wr_idx]       <= !mismatch;
      cursor_p1                <= cur_inc;
      if (cur_inc == len_p1) begin
        state_p1 <= DONE;
        busy_p1  <= 1'b0;
        done_p1  <= 1'b1;
      end
    end else if (acc_bs) begin
      type_p1[bs_idx*CW +: CW] <= '0;
      correct_p1[bs_idx]       <= 1'b0;
      cursor_p1                <= cur_dec;
    end
  end

  sat_counter #(.CNTW(CNTW)) u_keystrokes (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.start),
    .inc   (acc_char),
    .count (keys_cnt)
  );

  sat_counter #(.CNTW(CNTW)) u_errors (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.start),
    .inc   (err_inc),
    .count (errs_cnt)
  );

  assign bus.type_text  = type_p1;
  assign bus.correct    = correct_p1;
  assign bus.cursor     = cursor_p1;
  assign bus.keystrokes = keys_cnt;
  assign bus.errors     = errs_cnt;
  assign bus.busy       = busy_p1;
  assign bus.done       = done_p1;

endmodule

// File: tb/tb_type_buffer.sv
// Directed bench for type_buffer: a vector table for the race sequences plus
// hand-written checks for async reset, full-length races and counter saturation.
module tb_type_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  type_buffer_if #(.LEN(25), .CW(5), .CNTW(16)) bus ();
  type_buffer_if #(.LEN(25), .CW(5), .CNTW(2))  bus2 ();

  type_buffer #(.LEN(25), .CW(5), .CNTW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  type_buffer #(.LEN(25), .CW(5), .CNTW(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic         start;
    logic         kv;
    logic [4:0]   code;
    logic [4:0]   tlen;
    logic [4:0]   cur;
    logic [124:0] typ;
    logic [24:0]  cor;
    logic [15:0]  ks;
    logic [15:0]  er;
    logic         busy;
    logic         done;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [124:0] sl(input int a, input int b, input int c, input int d);
    logic [124:0] r;
    r = 125'(a) | (125'(b) << 5) | (125'(c) << 10) | (125'(d) << 15);
    return r;
  endfunction

  task automatic add(input logic st, input logic kv, input logic [4:0] code, input logic [4:0] tlen,
                     input logic [4:0] cur, input logic [124:0] typ, input logic [24:0] cor,
                     input logic [15:0] ks, input logic [15:0] er, input logic busy, input logic done);
    vec_t v;
    v.start = st; v.kv = kv; v.code = code; v.tlen = tlen;
    v.cur = cur; v.typ = typ; v.cor = cor; v.ks = ks; v.er = er; v.busy = busy; v.done = done;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] cur, input logic [124:0] typ,
                         input logic [24:0] cor, input logic [15:0] ks, input logic [15:0] er,
                         input logic busy, input logic done);
    chk({tag, " cursor"}, 128'(bus.cursor), 128'(cur));
    chk({tag, " type"}, 128'(bus.type_text), 128'(typ));
    chk({tag, " correct"}, 128'(bus.correct), 128'(cor));
    chk({tag, " keystrokes"}, 128'(bus.keystrokes), 128'(ks));
    chk({tag, " errors"}, 128'(bus.errors), 128'(er));
    chk({tag, " busy"}, 128'(bus.busy), 128'(busy));
    chk({tag, " done"}, 128'(bus.done), 128'(done));
  endtask

  // Inputs change at a falling edge, are sampled on the next rising edge and
  // results are read back at the following falling edge.
  task automatic step(input logic st, input logic kv, input logic [4:0] code, input logic [4:0] tlen);
    bus.start = st; bus.key_valid = kv; bus.key_code = code; bus.target_len = tlen;
    @(negedge clk);
    bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_code = 5'd0;
  endtask

  task automatic step2(input logic st, input logic kv, input logic [4:0] code, input logic [4:0] tlen);
    bus2.start = st; bus2.key_valid = kv; bus2.key_code = code; bus2.target_len = tlen;
    @(negedge clk);
    bus2.start = 1'b0; bus2.key_valid = 1'b0; bus2.key_code = 5'd0;
  endtask

  initial begin
    bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_code = 5'd0;
    bus.target = sl(3, 1, 20, 0); bus.target_len = 5'd3;
    bus2.start = 1'b0; bus2.key_valid = 1'b0; bus2.key_code = 5'd0;
    bus2.target = sl(3, 1, 20, 0); bus2.target_len = 5'd0;

    // Target "cat" = 3,1,20; remaining target slots are 0.
    add(0, 1, 3,  3, 0, '0, '0, 0, 0, 0, 0);                  // key in IDLE ignored
    add(1, 0, 0,  3, 0, '0, '0, 0, 0, 1, 0);                  // start
    add(0, 1, 3,  3, 1, sl(3,0,0,0),  25'b001, 1, 0, 1, 0);
    add(0, 1, 2,  3, 2, sl(3,2,0,0),  25'b001, 2, 1, 1, 0);   // mismatch
    add(0, 1, 31, 3, 1, sl(3,0,0,0),  25'b001, 2, 1, 1, 0);   // backspace
    add(0, 1, 1,  3, 2, sl(3,1,0,0),  25'b011, 3, 1, 1, 0);
    add(0, 1, 0,  3, 2, sl(3,1,0,0),  25'b011, 3, 1, 1, 0);   // code 0 ignored
    add(0, 1, 29, 3, 2, sl(3,1,0,0),  25'b011, 3, 1, 1, 0);   // code 29 ignored
    add(0, 0, 20, 3, 2, sl(3,1,0,0),  25'b011, 3, 1, 1, 0);   // no key_valid
    add(0, 1, 20, 3, 3, sl(3,1,20,0), 25'b111, 4, 1, 0, 1);   // last char -> DONE
    add(0, 1, 5,  3, 3, sl(3,1,20,0), 25'b111, 4, 1, 0, 1);   // frozen in DONE
    add(0, 1, 31, 3, 3, sl(3,1,20,0), 25'b111, 4, 1, 0, 1);
    add(1, 0, 0,  3, 0, '0, '0, 0, 0, 1, 0);                  // restart from DONE
    add(0, 1, 31, 3, 0, '0, '0, 0, 0, 1, 0);                  // BS at cursor 0
    add(0, 1, 3,  3, 1, sl(3,0,0,0),  25'b001, 1, 0, 1, 0);
    add(0, 1, 1,  3, 2, sl(3,1,0,0),  25'b011, 2, 0, 1, 0);
    add(0, 1, 27, 3, 3, sl(3,1,27,0), 25'b011, 3, 1, 0, 1);   // space vs 't'
    add(1, 0, 0,  3, 0, '0, '0, 0, 0, 1, 0);
    add(0, 1, 3,  3, 1, sl(3,0,0,0),  25'b001, 1, 0, 1, 0);
    add(0, 1, 1,  3, 2, sl(3,1,0,0),  25'b011, 2, 0, 1, 0);
    add(0, 1, 20, 3, 3, sl(3,1,20,0), 25'b111, 3, 0, 0, 1);   // clean "cat"
    add(1, 0, 0,  0, 0, '0, '0, 0, 0, 1, 0);                  // target_len 0 -> 25
    add(0, 1, 3,  0, 1, sl(3,0,0,0),  25'b0001, 1, 0, 1, 0);
    add(0, 1, 1,  0, 2, sl(3,1,0,0),  25'b0011, 2, 0, 1, 0);
    add(0, 1, 20, 0, 3, sl(3,1,20,0), 25'b0111, 3, 0, 1, 0);
    add(0, 1, 5,  0, 4, sl(3,1,20,5), 25'b0111, 4, 1, 1, 0);
    add(1, 1, 5,  0, 0, '0, '0, 0, 0, 1, 0);                  // start beats key

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_all("reset", 5'd0, '0, '0, 16'd0, 16'd0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].start, tbl[i].kv, tbl[i].code, tbl[i].tlen);
      chk_all($sformatf("v%0d", i), tbl[i].cur, tbl[i].typ, tbl[i].cor,
              tbl[i].ks, tbl[i].er, tbl[i].busy, tbl[i].done);
    end

    // Still TYPING with length 25 from the last table entry: fill the buffer with 'a'.
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 5'd1, 5'd0);
    chk("len0 cursor24", 128'(bus.cursor), 128'(24));
    chk("len0 busy24", 128'(bus.busy), 128'(1));
    chk("len0 done24", 128'(bus.done), 128'(0));
    chk("len0 errors24", 128'(bus.errors), 128'(23));
    chk("len0 correct24", 128'(bus.correct), 128'(25'b10));
    step(1'b0, 1'b1, 5'd1, 5'd0);
    chk("len0 cursor25", 128'(bus.cursor), 128'(25));
    chk("len0 done25", 128'(bus.done), 128'(1));
    chk("len0 busy25", 128'(bus.busy), 128'(0));
    chk("len0 keys25", 128'(bus.keystrokes), 128'(25));
    step(1'b0, 1'b1, 5'd2, 5'd0);
    chk("len0 frozen cursor", 128'(bus.cursor), 128'(25));

    // Asynchronous reset between clock edges in the middle of a race.
    step(1'b1, 1'b0, 5'd0, 5'd3);
    step(1'b0, 1'b1, 5'd3, 5'd3);
    step(1'b0, 1'b1, 5'd1, 5'd3);
    bus.target_len = 5'd0;
    step(1'b1, 1'b0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd3, 5'd0);
    step(1'b0, 1'b1, 5'd1, 5'd0);
    step(1'b0, 1'b1, 5'd20, 5'd0);
    chk("pre-reset cursor", 128'(bus.cursor), 128'(3));
    #1 rst = 1'b1;
    #1;
    chk_all("async reset", 5'd0, '0, '0, 16'd0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 2-bit counters: five mismatching keys must stick at 3.
    step2(1'b1, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) step2(1'b0, 1'b1, 5'd2, 5'd0);
    chk("sat keys3", 128'(bus2.keystrokes), 128'(3));
    chk("sat errs3", 128'(bus2.errors), 128'(3));
    for (int i = 0; i < 2; i++) step2(1'b0, 1'b1, 5'd2, 5'd0);
    chk("sat keys5", 128'(bus2.keystrokes), 128'(3));
    chk("sat errs5", 128'(bus2.errors), 128'(3));
    chk("sat cursor5", 128'(bus2.cursor), 128'(5));
    chk("sat busy5", 128'(bus2.busy), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
